// File: rtl/ahb_pkg.sv
// Shared AHB-Lite encodings and the SRAM slave state type.
package ahb_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic [2:0] HSIZE_BYTE = 3'b000;
    localparam logic [2:0] HSIZE_HALF = 3'b001;
    localparam logic [2:0] HSIZE_WORD = 3'b010;

    localparam logic RESP_OKAY  = 1'b0;
    localparam logic RESP_ERROR = 1'b1;

    typedef enum logic [2:0] {
        IDLE,
        WAIT,
        LAST,
        ERR1,
        ERR2
    } slave_state_e;

endpackage

// File: rtl/ahb_sram_array.sv
// Word-organised SRAM with per-byte write enables and combinational read.
module ahb_sram_array #(
    parameter int MEM_WORDS = 256,
    parameter int WW        = 8
) (
    input  logic          hclk,
    input  logic          we,
    input  logic [3:0]    be,
    input  logic [WW-1:0] addr,
    input  logic [31:0]   wdata,
    output logic [31:0]   rdata
);

    logic [31:0] mem [MEM_WORDS];

    always_ff @(posedge hclk) begin
        if (we) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) begin
                    mem[addr][8*i +: 8] <= wdata[8*i +: 8];
                end
            end
        end
    end

    assign rdata = mem[addr];

endmodule

// File: rtl/ahb_sram_slave.sv
// AHB-Lite SRAM slave: address/data pipeline, programmable wait states,
// two-cycle ERROR response.
//   state | meaning
//   IDLE  | no data phase in flight, ready
//   WAIT  | OKAY data phase, inserting wait states
//   LAST  | final OKAY data-phase cycle (write commits, read data valid)
//   ERR1  | first ERROR cycle, not ready
//   ERR2  | second ERROR cycle, ready
module ahb_sram_slave
    import ahb_pkg::*;
#(
    parameter int MEM_WORDS   = 256,
    parameter int WAIT_STATES = 1
) (
    input  logic        hclk,
    input  logic        hresetn,
    input  logic        hsel,
    input  logic        hready,
    input  logic [31:0] haddr,
    input  logic [1:0]  htrans,
    input  logic        hwrite,
    input  logic [2:0]  hsize,
    input  logic [31:0] hwdata,
    output logic [31:0] hrdata,
    output logic        hreadyout,
    output logic        hresp
);

    localparam int AW = $clog2(4 * MEM_WORDS);
    localparam int WW = AW - 2;

    slave_state_e state, state_nxt;
    logic [AW-1:0] addr_q;
    logic          write_q;
    logic [2:0]    size_q;
    logic [3:0]    cnt_q, cnt_nxt;
    logic          load;
    logic          accept;
    logic          addr_err;
    logic          mem_we;
    logic [3:0]    mem_be;
    logic [31:0]   mem_rdata;

    function automatic logic [3:0] lane_mask(input logic [2:0] size, input logic [1:0] a);
        case (size)
            HSIZE_BYTE: lane_mask = 4'b0001 << a;
            HSIZE_HALF: lane_mask = a[1] ? 4'b1100 : 4'b0011;
            default:    lane_mask = 4'b1111;
        endcase
    endfunction

    assign accept = hsel && hready && (htrans == HTRANS_NONSEQ || htrans == HTRANS_SEQ);

    assign addr_err = (hsize > HSIZE_WORD)
                   || (hsize == HSIZE_HALF && haddr[0])
                   || (hsize == HSIZE_WORD && haddr[1:0] != 2'b00)
                   || (haddr >= 32'(4 * MEM_WORDS));

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt_q;
        load      = 1'b0;
        case (state)
            IDLE, LAST, ERR2: begin
                state_nxt = IDLE;
                if (accept) begin
                    load = 1'b1;
                    if (addr_err) begin
                        state_nxt = ERR1;
                    end else if (WAIT_STATES == 0) begin
                        state_nxt = LAST;
                    end else begin
                        state_nxt = WAIT;
                        cnt_nxt   = 4'(WAIT_STATES);
                    end
                end
            end
            WAIT: begin
                if (cnt_q <= 4'd1) begin
                    state_nxt = LAST;
                end else begin
                    cnt_nxt = cnt_q - 4'd1;
                end
            end
            ERR1:    state_nxt = ERR2;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge hclk) begin
        if (!hresetn) begin
            state   <= IDLE;
            addr_q  <= '0;
            write_q <= 1'b0;
            size_q  <= HSIZE_BYTE;
            cnt_q   <= '0;
        end else begin
            state <= state_nxt;
            cnt_q <= cnt_nxt;
            if (load) begin
                addr_q  <= haddr[AW-1:0];
                write_q <= hwrite;
                size_q  <= hsize;
            end
        end
    end

    // Gate with hresetn so a reset landing on LAST drops the write.
    assign mem_we = (state == LAST) && write_q && hresetn;
    assign mem_be = lane_mask(size_q, addr_q[1:0]);

    ahb_sram_array #(
        .MEM_WORDS (MEM_WORDS),
        .WW        (WW)
    ) u_array (
        .hclk  (hclk),
        .we    (mem_we),
        .be    (mem_be),
        .addr  (addr_q[AW-1:2]),
        .wdata (hwdata),
        .rdata (mem_rdata)
    );

    assign hreadyout = (state != WAIT) && (state != ERR1);
    assign hresp     = (state == ERR1 || state == ERR2) ? RESP_ERROR : RESP_OKAY;
    assign hrdata    = (state == LAST && !write_q) ? mem_rdata : 32'h0;

endmodule
